mem_access_ctrl: RTL and testbench

Multi-cycle data-memory access sequencer between the single-cycle core's decode/ALU stage and the data-memory bus. It consumes the decoder's MemRead/MemWrite/MemSign/MemWidth and the ALU-computed address. It issues aligned 64-bit bus beats with a req/ready handshake, splitting misaligned accesses into two beats. It stalls the core until the access completes and returns lane-aligned, sign- or zero-extended load data.

---
 rtl/mem_ctrl_pkg.sv | 37 +++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the data-memory access sequencer.
package mem_ctrl_pkg;

  localparam int BEAT_BYTES = 8;

  typedef enum logic [1:0] {
    MW_BYTE   = 2'd0,
    MW_HALF   = 2'd1,
    MW_WORD   = 2'd2,
    MW_DOUBLE = 2'd3
  } mem_width_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } mac_state_e;

  // One bit per byte the access touches, starting at lane 0.
  function automatic logic [7:0] sizeMask(input mem_width_e width);
    case (width)
      MW_BYTE:  return 8'h01;
      MW_HALF:  return 8'h03;
      MW_WORD:  return 8'h0F;
      default:  return 8'hFF;
    endcase
  endfunction

  // True when the access runs past the end of its 8-byte beat.
  function automatic logic isSplit(input logic [2:0] off, input mem_width_e width);
    logic [4:0] endByte;
    endByte = {2'b00, off} + (5'd1 << width);
    return endByte > 5'(BEAT_BYTES);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: positions store data/strobes across two beats
// and extracts/extends load data from the two-beat buffer.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  mem_width_e  width_i,
  input  logic        sign_i,
  input  logic [2:0]  off_i,
  input  logic [63:0] storeData_i,
  input  logic [63:0] loadLo_i,
  input  logic [63:0] loadHi_i,
  output logic [7:0]  strbLo_o,
  output logic [7:0]  strbHi_o,
  output logic [63:0] wdataLo_o,
  output logic [63:0] wdataHi_o,
  output logic [63:0] loadData_o
);

  logic [7:0]   laneMask;
  logic [63:0]  byteMask64;
  logic [15:0]  strb16;
  logic [127:0] data128;
  logic [63:0]  loadShift;

  // Shift masked store data and strobes into a 16-byte window; extract the load.
  always_comb begin
    laneMask   = sizeMask(width_i);
    byteMask64 = '0;
    for (int i = 0; i < 8; i++) begin
      byteMask64[8*i +: 8] = {8{laneMask[i]}};
    end
    strb16    = {8'b0, laneMask} << off_i;
    data128   = {64'b0, storeData_i & byteMask64} << {off_i, 3'b000};
    loadShift = 64'({loadHi_i, loadLo_i} >> {off_i, 3'b000});
    loadData_o = '0;
    case (width_i)
      MW_BYTE:  loadData_o = sign_i ? {56'b0, loadShift[7:0]}
                                    : {{56{loadShift[7]}}, loadShift[7:0]};
      MW_HALF:  loadData_o = sign_i ? {48'b0, loadShift[15:0]}
                                    : {{48{loadShift[15]}}, loadShift[15:0]};
      MW_WORD:  loadData_o = sign_i ? {32'b0, loadShift[31:0]}
                                    : {{32{loadShift[31]}}, loadShift[31:0]};
      default:  loadData_o = loadShift;
    endcase
  end

  assign strbLo_o  = strb16[7:0];
  assign strbHi_o  = strb16[15:8];
  assign wdataLo_o = data128[63:0];
  assign wdataHi_o = data128[127:64];

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: stalls the core, issues one or two aligned
// bus beats, and returns extended load data.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int REG_WIDTH  = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_sign,
  input  logic [1:0]            mem_width,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [REG_WIDTH-1:0]  wdata,
  output logic                  stall,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [REG_WIDTH-1:0]  bus_wdata,
  output logic [7:0]            bus_wstrb,
  input  logic                  bus_ready,
  input  logic [REG_WIDTH-1:0]  bus_rdata
);

  mac_state_e            state_q, state_d;
  logic                  isRead_q;
  mem_width_e            width_q;
  logic                  sign_q;
  logic [2:0]            off_q;
  logic                  split_q;
  logic [ADDR_WIDTH-1:0] baseAddr_q;
  logic [REG_WIDTH-1:0]  wdata_q;
  logic [REG_WIDTH-1:0]  buf0_q, buf1_q, rdata_q;

  logic                  live, onHigh, beatAccept;
  logic [7:0]            strbLo, strbHi;
  logic [REG_WIDTH-1:0]  wdataLo, wdataHi, loadLo, loadHi, loadData;

  assign live       = mem_read | mem_write;
  assign stall      = !rst && live && (state_q != DONE);
  assign beatAccept = bus_req && bus_ready;
  assign onHigh     = (state_q == BEAT1);
  assign rdata      = rdata_q;

  // The beat being accepted is fed straight in so rdata is ready in DONE.
  assign loadLo = (state_q == BEAT0) ? bus_rdata : buf0_q;
  assign loadHi = (state_q == BEAT1) ? bus_rdata : buf1_q;

  mem_lane_align u_align (
    .width_i     (width_q),
    .sign_i      (sign_q),
    .off_i       (off_q),
    .storeData_i (wdata_q),
    .loadLo_i    (loadLo),
    .loadHi_i    (loadHi),
    .strbLo_o    (strbLo),
    .strbHi_o    (strbHi),
    .wdataLo_o   (wdataLo),
    .wdataHi_o   (wdataHi),
    .loadData_o  (loadData)
  );

  // Sequencer next state: one beat, or two when the access straddles a beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (live) state_d = BEAT0;
      BEAT0:   if (bus_ready) state_d = split_q ? BEAT1 : DONE;
      BEAT1:   if (bus_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decoded from state and latched request copies only.
  always_comb begin
    bus_req   = (state_q == BEAT0) || (state_q == BEAT1);
    bus_addr  = '0;
    bus_we    = 1'b0;
    bus_wstrb = '0;
    bus_wdata = '0;
    if (bus_req) begin
      bus_addr = onHigh ? baseAddr_q + ADDR_WIDTH'(BEAT_BYTES) : baseAddr_q;
      bus_we   = !isRead_q;
      if (!isRead_q) begin
        bus_wstrb = onHigh ? strbHi : strbLo;
        bus_wdata = onHigh ? wdataHi : wdataLo;
      end
    end
  end

  // State register plus request capture, read buffers and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      isRead_q   <= 1'b0;
      width_q    <= MW_BYTE;
      sign_q     <= 1'b0;
      off_q      <= '0;
      split_q    <= 1'b0;
      baseAddr_q <= '0;
      wdata_q    <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && live) begin
        isRead_q   <= mem_read;
        width_q    <= mem_width_e'(mem_width);
        sign_q     <= mem_sign;
        off_q      <= addr[2:0];
        split_q    <= isSplit(addr[2:0], mem_width_e'(mem_width));
        baseAddr_q <= {addr[ADDR_WIDTH-1:3], 3'b000};
        wdata_q    <= wdata;
      end
      if (beatAccept && isRead_q) begin
        if (state_q == BEAT0) buf0_q <= bus_rdata;
        else                  buf1_q <= bus_rdata;
      end
      if (beatAccept && isRead_q && state_d == DONE) begin
        rdata_q <= loadData;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: byte-addressed memory model and a bus slave memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, mem_sign;
  logic [1:0]  mem_width;
  logic [63:0] addr, wdata;
  logic        stall;
  logic [63:0] rdata;
  logic        bus_req, bus_we;
  logic [63:0] bus_addr, bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_ready;
  logic [63:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  strb;
    logic [63:0] data;
  } beat_t;

  beat_t       expBeats[$];
  logic [7:0]  refMem[logic [63:0]];
  logic [7:0]  slvMem[logic [63:0]];

  logic [63:0] obsAddr[2];
  logic [7:0]  obsStrb[2];
  logic [63:0] obsData[2];
  int          obsStall;
  logic [63:0] obsRdata;

  // Free-running core clock.
  always #5 clk = ~clk;

  mem_access_ctrl #(.REG_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_sign  (mem_sign),
    .mem_width (mem_width),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata)
  );

  function automatic logic [7:0] defaultByte(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] refByte(input logic [63:0] a);
    if (refMem.exists(a)) return refMem[a];
    return defaultByte(a);
  endfunction

  function automatic logic [7:0] slvByte(input logic [63:0] a);
    if (slvMem.exists(a)) return slvMem[a];
    return defaultByte(a);
  endfunction

  // Place a little-endian doubleword in both memories.
  task automatic preload(input logic [63:0] a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) begin
      refMem[a + 64'(i)] = v[8*i +: 8];
      slvMem[a + 64'(i)] = v[8*i +: 8];
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, actual, expected);
    end
  endtask

  // Runs one access; lowCycles < 0 means random bus wait states.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] width, input logic sgn,
                               input logic [63:0] a, input logic [63:0] wd, input int lowCycles);
    int          size, off, lows, totalLows, nBeats;
    logic        isRead, ready;
    logic [63:0] expRd, rv;
    beat_t       b0, b1, e;
    bit          done;

    size   = 1 << int'(width);
    off    = int'(a[2:0]);
    isRead = rd;
    b0.addr = a & ~64'd7;
    b0.we   = !isRead;
    b0.strb = '0;
    b0.data = '0;
    b1.addr = b0.addr + 64'd8;
    b1.we   = !isRead;
    b1.strb = '0;
    b1.data = '0;
    expRd   = '0;
    for (int i = 0; i < size; i++) begin
      int pos;
      pos = off + i;
      if (!isRead) begin
        if (pos < 8) begin
          b0.strb[pos]          = 1'b1;
          b0.data[8*pos +: 8]   = wd[8*i +: 8];
        end else begin
          b1.strb[pos-8]        = 1'b1;
          b1.data[8*(pos-8) +: 8] = wd[8*i +: 8];
        end
      end
      expRd[8*i +: 8] = refByte(a + 64'(i));
    end
    if (!sgn && expRd[8*size-1]) begin
      for (int j = size; j < 8; j++) expRd[8*j +: 8] = 8'hFF;
    end
    if (!isRead) begin
      for (int i = 0; i < size; i++) refMem[a + 64'(i)] = wd[8*i +: 8];
    end
    expBeats.delete();
    expBeats.push_back(b0);
    if (off + size > 8) expBeats.push_back(b1);
    nBeats = expBeats.size();

    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    mem_width = width;
    mem_sign  = sgn;
    addr      = a;
    wdata     = wd;
    bus_ready = 1'b0;
    #1;
    checkOutput("stall_on_request", 64'(stall), 64'd1);
    checkOutput("idle_no_req", 64'(bus_req), 64'd0);
    obsStall  = 1;
    lows      = 0;
    totalLows = 0;
    done      = 0;
    for (int beatIdx = 0, cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (bus_req) begin
        if (stall) obsStall++;
        checkOutput("beat_stall", 64'(stall), 64'd1);
        if (expBeats.size() == 0) begin
          checkOutput("extra_beat", 64'd1, 64'd0);
          ready = 1'b1;
        end else begin
          e = expBeats[0];
          checkOutput("beat_addr", bus_addr, e.addr);
          checkOutput("beat_we", 64'(bus_we), 64'(e.we));
          checkOutput("beat_wstrb", 64'(bus_wstrb), 64'(e.strb));
          if (!isRead) checkOutput("beat_wdata", bus_wdata, e.data);
          if (beatIdx < 2) begin
            obsAddr[beatIdx] = bus_addr;
            obsStrb[beatIdx] = bus_wstrb;
            obsData[beatIdx] = bus_wdata;
          end
          if (lowCycles < 0) ready = ($urandom_range(0, 2) != 0);
          else               ready = (lows == lowCycles);
        end
        if (ready) begin
          for (int l = 0; l < 8; l++) begin
            rv[8*l +: 8] = slvByte(bus_addr + 64'(l));
            if (bus_we && bus_wstrb[l]) slvMem[bus_addr + 64'(l)] = bus_wdata[8*l +: 8];
          end
          bus_rdata = rv;
          if (expBeats.size() != 0) void'(expBeats.pop_front());
          beatIdx++;
          lows = 0;
        end else begin
          bus_rdata = {$urandom, $urandom};
          lows++;
          totalLows++;
        end
        bus_ready = ready;
      end else begin
        checkOutput("done_stall", 64'(stall), 64'd0);
        checkOutput("beats_left", 64'(expBeats.size()), 64'd0);
        if (isRead) checkOutput("load_data", rdata, expRd);
        checkOutput("stall_cycles", 64'(obsStall), 64'(1 + nBeats + totalLows));
        obsRdata  = rdata;
        done      = 1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_ready = 1'b0;
      end
    end
    if (!done) begin
      checkOutput("txn_timeout", 64'd0, 64'd1);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      bus_ready = 1'b0;
    end
  endtask

  // Hard stop in case the sequence itself wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed cases followed by randomized traffic.
  initial begin
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_sign = 1'b0; mem_width = 2'd0;
    addr = '0; wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    mem_read = 1'b1;
    #1;
    checkOutput("reset_stall", 64'(stall), 64'd0);
    checkOutput("reset_bus_req", 64'(bus_req), 64'd0);
    checkOutput("reset_wstrb", 64'(bus_wstrb), 64'd0);
    checkOutput("reset_rdata", rdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_read = 1'b0;

    preload(64'h1000, 64'h80000001_00000000);
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 64'h1004, 64'd0, 0);
    checkOutput("lw_sext", obsRdata, 64'hFFFFFFFF_80000001);
    checkOutput("lw_stall", 64'(obsStall), 64'd2);
    checkOutput("lw_addr", obsAddr[0], 64'h1000);
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b1, 64'h1004, 64'd0, 0);
    checkOutput("lwu_zext", obsRdata, 64'h00000000_80000001);

    preload(64'h1000, 64'hBBAA0000_00000000);
    preload(64'h1008, 64'h00006655_44332211);
    applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 64'h1006, 64'd0, 0);
    checkOutput("ld_split", obsRdata, 64'h66554433_2211BBAA);
    checkOutput("ld_split_stall", 64'(obsStall), 64'd3);

    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 64'h2007, 64'h0000BEEF, 0);
    checkOutput("sh_addr0", obsAddr[0], 64'h2000);
    checkOutput("sh_strb0", 64'(obsStrb[0]), 64'h80);
    checkOutput("sh_data0", obsData[0], 64'hEF000000_00000000);
    checkOutput("sh_addr1", obsAddr[1], 64'h2008);
    checkOutput("sh_strb1", 64'(obsStrb[1]), 64'h01);
    checkOutput("sh_data1", obsData[1], 64'h00000000_000000BE);

    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 64'h3003, 64'h12345678_9ABCDEF0, 3);
    checkOutput("sb_wait_stall", 64'(obsStall), 64'd5);
    checkOutput("sb_addr", obsAddr[0], 64'h3000);
    checkOutput("sb_strb", 64'(obsStrb[0]), 64'h08);

    applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1);
    checkOutput("wrap_addr0", obsAddr[0], 64'hFFFF_FFFF_FFFF_FFF8);
    checkOutput("wrap_addr1", obsAddr[1], 64'h0);

    applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 64'h5000, 64'hDEADBEEF_CAFEF00D, 0);
    checkOutput("both_strb", 64'(obsStrb[0]), 64'h00);

    // Reset while the second beat of a split load is outstanding.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; mem_width = 2'd3; mem_sign = 1'b0;
    addr = 64'h1006; bus_ready = 1'b0;
    @(negedge clk);
    bus_ready = 1'b1;
    bus_rdata = 64'hBBAA0000_00000000;
    @(negedge clk);
    checkOutput("rst_in_beat1", 64'(bus_req), 64'd1);
    rst = 1'b1;
    bus_ready = 1'b0;
    #1;
    checkOutput("rst_stall_low", 64'(stall), 64'd0);
    @(negedge clk);
    checkOutput("rst_after_req", 64'(bus_req), 64'd0);
    checkOutput("rst_after_rdata", rdata, 64'd0);
    checkOutput("rst_after_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    mem_read = 1'b0;
    preload(64'h6000, 64'h00F00000_00000000);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 64'h6006, 64'd0, 0);
    checkOutput("lb_after_rst", obsRdata, 64'hFFFFFFFF_FFFFFFF0);

    for (int t = 0; t < 150; t++) begin
      int op;
      logic [63:0] ra;
      op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) ra = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      else                           ra = 64'h4000 + 64'($urandom_range(0, 47));
      applyStimulus(op != 1, op != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ra, {$urandom, $urandom}, -1);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
